// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the pipeline datapath and the fetch sequencer.
// The hazard/branch inputs flow in, and the PC and pipeline-register controls flow out.
interface fetch_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic [4:0]       id_rn;
    logic [4:0]       id_rm;
    logic             id_uses_rm;
    logic             br_taken;
    logic             halt_req;
    logic             pc_we;
    logic             pc_sel_branch;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ex_mem_read, ex_rd, id_rn, id_rm, id_uses_rm, br_taken, halt_req,
        input  pc_we, pc_sel_branch, ifid_we, ifid_flush, idex_bubble,
        input  state_o, stall_count, flush_count
    );

    modport slave (
        input  ex_mem_read, ex_rd, id_rn, id_rm, id_uses_rm, br_taken, halt_req,
        output pc_we, pc_sel_branch, ifid_we, ifid_flush, idex_bubble,
        output state_o, stall_count, flush_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC / IF-ID / ID-EX control for the 5-stage core. It handles the startup fill,
// load-use stalls, taken-branch flushes, and a sticky halt, and it keeps saturating event counters.
module fetch_sequencer #(
    parameter int STARTUP_CYCLES = 2,
    parameter int FLUSH_CYCLES   = 1,
    parameter int CNT_W          = 32
) (
    input logic               clk,
    input logic               rst,
    fetch_sequencer_if.slave  bus
);
    localparam int MAX_P = (STARTUP_CYCLES > FLUSH_CYCLES) ? STARTUP_CYCLES : FLUSH_CYCLES;
    localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam logic [CW-1:0] STARTUP_RELOAD = CW'(STARTUP_CYCLES - 1);
    localparam logic [CW-1:0] FLUSH_RELOAD   = (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 2) : '0;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        HALT  = 3'd3
    } state_t;

    state_t           state, nextState;
    logic [CW-1:0]    cnt, nextCnt;
    logic [CNT_W-1:0] stallCnt, flushCnt;
    logic             stallInc, flushInc;
    logic             pcWe, pcSelBranch, ifidWe, ifidFlush, idexBubble;
    logic             hazard;

    // X31 reads as XZR, so a load targeting it can never feed a consumer.
    assign hazard = bus.ex_mem_read && (bus.ex_rd != 5'd31) &&
                    ((bus.ex_rd == bus.id_rn) || (bus.id_uses_rm && (bus.ex_rd == bus.id_rm)));

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        pcWe        = 1'b0;
        pcSelBranch = 1'b0;
        ifidWe      = 1'b0;
        ifidFlush   = 1'b0;
        idexBubble  = 1'b0;
        nextState   = state;
        nextCnt     = cnt;
        stallInc    = 1'b0;
        flushInc    = 1'b0;
        case (state)
            INIT: begin
                ifidFlush  = 1'b1;
                idexBubble = 1'b1;
                if (cnt == '0) nextState = RUN;
                else           nextCnt   = cnt - CW'(1);
            end
            RUN: begin
                if (bus.halt_req) begin
                    idexBubble = 1'b1;
                    nextState  = HALT;
                end else if (bus.br_taken) begin
                    // The instruction stalled by a concurrent hazard is squashed, so the stall is dropped.
                    pcWe        = 1'b1;
                    pcSelBranch = 1'b1;
                    ifidWe      = 1'b1;
                    ifidFlush   = 1'b1;
                    flushInc    = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        nextState = FLUSH;
                        nextCnt   = FLUSH_RELOAD;
                    end
                end else if (hazard) begin
                    idexBubble = 1'b1;
                    stallInc   = 1'b1;
                end else begin
                    pcWe   = 1'b1;
                    ifidWe = 1'b1;
                end
            end
            FLUSH: begin
                if (bus.halt_req) begin
                    idexBubble = 1'b1;
                    nextState  = HALT;
                end else begin
                    pcWe       = 1'b1;
                    ifidWe     = 1'b1;
                    ifidFlush  = 1'b1;
                    idexBubble = 1'b1;
                    flushInc   = 1'b1;
                    if (cnt == '0) nextState = RUN;
                    else           nextCnt   = cnt - CW'(1);
                end
            end
            HALT: begin
                idexBubble = 1'b1;
            end
            default: begin
                ifidFlush  = 1'b1;
                idexBubble = 1'b1;
                nextState  = INIT;
                nextCnt    = STARTUP_RELOAD;
            end
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            cnt      <= STARTUP_RELOAD;
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            if (stallInc && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
            if (flushInc && (flushCnt != '1)) flushCnt <= flushCnt + CNT_W'(1);
        end
    end

    assign bus.pc_we         = pcWe;
    assign bus.pc_sel_branch = pcSelBranch;
    assign bus.ifid_we       = ifidWe;
    assign bus.ifid_flush    = ifidFlush;
    assign bus.idex_bubble   = idexBubble;
    assign bus.state_o       = state;
    assign bus.stall_count   = stallCnt;
    assign bus.flush_count   = flushCnt;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer. The driver queues the hand-computed expected response for each cycle,
// and the monitor pops that response on the falling edge and compares it.
module tb_fetch_sequencer;
    localparam int CNT_W = 4;

    typedef struct {
        string      name;
        logic [4:0] outs;     // {pc_we, pc_sel_branch, ifid_we, ifid_flush, idex_bubble}
        logic [2:0] st;
        logic       chkCnt;
        logic [3:0] stall;
        logic [3:0] flush;
    } exp_t;

    localparam logic [4:0] O_INIT   = 5'b00011;
    localparam logic [4:0] O_NORM   = 5'b10100;
    localparam logic [4:0] O_STALL  = 5'b00001;
    localparam logic [4:0] O_BRANCH = 5'b11110;
    localparam logic [4:0] O_FLUSH  = 5'b10111;
    localparam logic [4:0] O_HALT   = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    fetch_sequencer_if #(.CNT_W(CNT_W)) bus ();

    fetch_sequencer #(
        .STARTUP_CYCLES(2),
        .FLUSH_CYCLES  (2),
        .CNT_W         (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic uses, input logic br, input logic halt);
        bus.ex_mem_read = mr;
        bus.ex_rd       = rd;
        bus.id_rn       = rn;
        bus.id_rm       = rm;
        bus.id_uses_rm  = uses;
        bus.br_taken    = br;
        bus.halt_req    = halt;
    endtask

    task automatic expect_cycle(input string name, input logic [4:0] outs, input logic [2:0] st,
                                input logic chk, input logic [3:0] stall, input logic [3:0] flush);
        exp_t e;
        e.name = name; e.outs = outs; e.st = st; e.chkCnt = chk; e.stall = stall; e.flush = flush;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_now(input string name);
        check({name, "_outs"}, 32'({bus.pc_we, bus.pc_sel_branch, bus.ifid_we, bus.ifid_flush, bus.idex_bubble}), 32'(O_INIT));
        check({name, "_state"}, 32'(bus.state_o), 32'd0);
        check({name, "_stall"}, 32'(bus.stall_count), 32'd0);
        check({name, "_flush"}, 32'(bus.flush_count), 32'd0);
    endtask

    // Monitor: one expectation is consumed per falling edge while any are pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, "_outs"},
                      32'({bus.pc_we, bus.pc_sel_branch, bus.ifid_we, bus.ifid_flush, bus.idex_bubble}),
                      32'(e.outs));
                check({e.name, "_state"}, 32'(bus.state_o), 32'(e.st));
                if (e.chkCnt) begin
                    check({e.name, "_stall"}, 32'(bus.stall_count), 32'(e.stall));
                    check({e.name, "_flush"}, 32'(bus.flush_count), 32'(e.flush));
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        idle();
        rst = 1'b1;
        tick();
        expect_cycle("reset", O_INIT, 3'd0, 1'b1, 4'd0, 4'd0);
        tick();
        rst = 1'b0;

        // Startup fill: two INIT cycles, and halt_req is ignored there.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        expect_cycle("init0_halt", O_INIT, 3'd0, 1'b1, 4'd0, 4'd0); tick();
        expect_cycle("init1_halt", O_INIT, 3'd0, 1'b1, 4'd0, 4'd0); tick();

        idle();
        expect_cycle("run_first", O_NORM, 3'd1, 1'b1, 4'd0, 4'd0); tick();
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_cycle("hazard_rn", O_STALL, 3'd1, 1'b1, 4'd0, 4'd0); tick();
        drive(1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_cycle("xzr_no_hz", O_NORM, 3'd1, 1'b1, 4'd1, 4'd0); tick();
        drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0);
        expect_cycle("rm_unused", O_NORM, 3'd1, 1'b1, 4'd1, 4'd0); tick();
        drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
        expect_cycle("hazard_rm", O_STALL, 3'd1, 1'b1, 4'd1, 4'd0); tick();

        // Taken branch: one branch cycle followed by one FLUSH cycle, then back to RUN.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        expect_cycle("branch", O_BRANCH, 3'd1, 1'b1, 4'd2, 4'd0); tick();
        idle();
        expect_cycle("flush_cyc", O_FLUSH, 3'd2, 1'b1, 4'd2, 4'd1); tick();
        expect_cycle("post_flush", O_NORM, 3'd1, 1'b1, 4'd2, 4'd2); tick();

        // The branch wins over a concurrent hazard, and FLUSH ignores br_taken and hazards.
        drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        expect_cycle("br_vs_hz", O_BRANCH, 3'd1, 1'b1, 4'd2, 4'd2); tick();
        expect_cycle("flush_ign", O_FLUSH, 3'd2, 1'b1, 4'd2, 4'd3); tick();
        idle();
        expect_cycle("run_again", O_NORM, 3'd1, 1'b1, 4'd2, 4'd4); tick();

        // Halt from RUN is sticky.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        expect_cycle("halt_run", O_HALT, 3'd1, 1'b1, 4'd2, 4'd4); tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        expect_cycle("halted_br", O_HALT, 3'd3, 1'b1, 4'd2, 4'd4); tick();
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_cycle("halted_hz", O_HALT, 3'd3, 1'b1, 4'd2, 4'd4); tick();

        // Reset leaves HALT and clears the counters without waiting for a clock edge.
        idle();
        rst = 1'b1;
        #1;
        check_reset_now("rst_from_halt");
        tick();
        rst = 1'b0;
        expect_cycle("init0_b", O_INIT, 3'd0, 1'b1, 4'd0, 4'd0); tick();
        expect_cycle("init1_b", O_INIT, 3'd0, 1'b1, 4'd0, 4'd0); tick();

        // Halt accepted during FLUSH.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        expect_cycle("branch_b", O_BRANCH, 3'd1, 1'b1, 4'd0, 4'd0); tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        expect_cycle("halt_flush", O_HALT, 3'd2, 1'b1, 4'd0, 4'd1); tick();
        idle();
        expect_cycle("halted_b", O_HALT, 3'd3, 1'b0, 4'd0, 4'd0); tick();

        // Stall counter saturation at 15 with a 4-bit counter.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        drive(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 17; k++) begin
            expect_cycle($sformatf("sat_%0d", k), O_STALL, 3'd1, 1'b1, (k > 15) ? 4'd15 : 4'(k), 4'd0);
            tick();
        end
        idle();
        expect_cycle("sat_hold", O_NORM, 3'd1, 1'b1, 4'd15, 4'd0); tick();

        // An asynchronous reset in the middle of FLUSH abandons the flush.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        expect_cycle("branch_c", O_BRANCH, 3'd1, 1'b1, 4'd15, 4'd0); tick();
        idle();
        expect_cycle("flush_c", O_FLUSH, 3'd2, 1'b1, 4'd15, 4'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_now("rst_mid_flush");
        tick();
        rst = 1'b0;

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 5) begin
            tick();
            wait_cycles++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
